rbcp_reg_bank: RTL and testbench
================================

// Module: rbcp_reg_bank
// PURPOSE
//  RBCP local-bus slave sitting directly downstream of the SiTCP core's LOC_* interface.
//  Decodes LOC_ADDR into two regions:
//   - a bank of NREG 8-bit control registers held in this block;
//   - an external window forwarded to user logic, with a timeout.
//  Returns LOC_ACK/LOC_RD to the core. A missing ACK makes the core reply with a bus error.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  first address of the local register bank
//  NREG       16             number of local 8-bit registers (2..256)
//  VERSION    8'h01          value read back from local register 0
//  EXT_BASE   32'h0000_1000  first address of the external window
//  EXT_AW     12             external window size = 2**EXT_AW bytes
//  TIMEOUT    255            max cycles to wait for EXT_ACK (1..255)
// PORTS
//  CLK          in   1        system clock
//  RSTn         in   1        synchronous reset, active low
//  LOC_ACT      in   1        RBCP transaction active
//  LOC_ADDR     in   32       access address
//  LOC_WD       in   8        write data
//  LOC_WE       in   1        write strobe, 1-cycle pulse
//  LOC_RE       in   1        read strobe, 1-cycle pulse
//  LOC_ACK      out  1        access acknowledge, 1-cycle pulse
//  LOC_RD       out  8        read data, valid while LOC_ACK=1
//  REG_OUT      out  8*NREG   local register contents; byte i = register i
//  SOFT_RST     out  1        1-cycle pulse on any write to register 0
//  EXT_ADDR     out  EXT_AW   external offset (LOC_ADDR-EXT_BASE), held during access
//  EXT_WD       out  8        external write data, held during access
//  EXT_WE       out  1        external write strobe, 1-cycle pulse
//  EXT_RE       out  1        external read strobe, 1-cycle pulse
//  EXT_ACK      in   1        external acknowledge
//  EXT_RD       in   8        external read data, sampled when EXT_ACK=1
//  TO_CNT       out  8        saturating count of external timeouts
// BEHAVIOUR
//  Reset (RSTn=0 at a rising CLK edge):
//   - all outputs, REG_OUT, TO_CNT and the timeout counter go to 0; FSM goes to IDLE.
//   - an in-flight access is abandoned: no ACK is issued afterwards.
//  Strobe validity:
//   - a strobe counts only when LOC_ACT=1 and the FSM is in IDLE.
//   - strobes arriving in EXT_WAIT or ACK are ignored.
//   - WE and RE together: treated as a write only; one ACK.
//  FSM states: IDLE, ACK, EXT_WAIT.
//  IDLE, local hit (BASE_ADDR <= addr < BASE_ADDR+NREG, 32-bit unsigned compare):
//   - write: register (addr-BASE_ADDR) <= LOC_WD at this edge; go to ACK.
//   - register 0 is read-only: a write leaves it unchanged, pulses SOFT_RST the next cycle, still ACKs.
//   - read: capture the register (reg 0 returns VERSION) into LOC_RD; go to ACK.
//  IDLE, external hit (EXT_BASE <= addr < EXT_BASE+2**EXT_AW):
//   - next cycle: EXT_ADDR/EXT_WD valid and EXT_WE or EXT_RE pulses for 1 cycle.
//   - enter EXT_WAIT with the timeout counter cleared.
//  IDLE, miss (neither region): no ACK, stay in IDLE.
//  ACK: LOC_ACK=1 for exactly one cycle, then IDLE. Local access latency is strobe + 1 cycle.
//  EXT_WAIT:
//   - EXT_ACK=1 in the strobe cycle or later: next cycle LOC_ACK=1, LOC_RD=EXT_RD (0 for writes), then IDLE.
//   - EXT_ACK in the same cycle as the strobe pulse is accepted.
//   - the counter increments each cycle without EXT_ACK.
//   - on reaching TIMEOUT: go to IDLE with no LOC_ACK; TO_CNT += 1, saturating at 8'hFF.
//   - EXT_ACK outside EXT_WAIT is ignored.
//  Data hold and width:
//   - LOC_RD = 0 whenever LOC_ACK = 0.
//   - REG_OUT holds its value across all other accesses.
//   - address offset is LOC_ADDR-region base, truncated to the region width.
//  Overlapping regions: the local bank has priority.
// TESTING
//  1 Write 8'hA5 to BASE_ADDR+3, then read it -> ACK 1 cycle after each strobe; LOC_RD=A5; REG_OUT[31:24]=A5.
//  2 Read BASE_ADDR+0 -> LOC_RD=VERSION. Write 8'h55 to it -> SOFT_RST pulse, ACK, register reads VERSION again.
//  3 Read EXT_BASE+7, EXT_ACK after 5 cycles with EXT_RD=3C -> EXT_ADDR=7, EXT_RE pulse, LOC_ACK next cycle, LOC_RD=3C.
//  4 Ext write, EXT_ACK never asserted -> no LOC_ACK, IDLE after TIMEOUT cycles, TO_CNT=1; 300 timeouts -> TO_CNT=FF.
//  5 Access to BASE_ADDR+NREG, and a strobe with LOC_ACT=0 -> no ACK, REG_OUT unchanged.
//  6 RSTn=0 during EXT_WAIT, then EXT_ACK -> no LOC_ACK, all outputs 0. WE+RE together -> write done, single ACK.

Source files
------------

// File: rtl/rbcp_reg_bank_if.sv
// RBCP local-bus and external-window signal bundle between the SiTCP core side,
// the register bank and the user logic behind the external window.
interface rbcp_reg_bank_if #(
  parameter int EXT_AW = 12
);
  logic              loc_act;
  logic [31:0]       loc_addr;
  logic [7:0]        loc_wd;
  logic              loc_we;
  logic              loc_re;
  logic              loc_ack;
  logic [7:0]        loc_rd;
  logic [EXT_AW-1:0] ext_addr;
  logic [7:0]        ext_wd;
  logic              ext_we;
  logic              ext_re;
  logic              ext_ack;
  logic [7:0]        ext_rd;

  modport slave (
    input  loc_act, loc_addr, loc_wd, loc_we, loc_re, ext_ack, ext_rd,
    output loc_ack, loc_rd, ext_addr, ext_wd, ext_we, ext_re
  );

  modport master (
    output loc_act, loc_addr, loc_wd, loc_we, loc_re, ext_ack, ext_rd,
    input  loc_ack, loc_rd, ext_addr, ext_wd, ext_we, ext_re
  );
endinterface

// File: rtl/rbcp_reg_bank.sv
// RBCP local-bus slave: a bank of 8-bit control registers plus a forwarded
// external window with an acknowledge timeout and saturating timeout counter.
module rbcp_reg_bank #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NREG      = 16,
  parameter logic [7:0]  VERSION   = 8'h01,
  parameter logic [31:0] EXT_BASE  = 32'h0000_1000,
  parameter int          EXT_AW    = 12,
  parameter int          TIMEOUT   = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  rbcp_reg_bank_if.slave    bus,
  output logic [8*NREG-1:0] reg_out_o,
  output logic              soft_rst_o,
  output logic [7:0]        to_cnt_o
);

  localparam int IW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    EXT_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        regs_q [NREG];
  logic [7:0]        regs_d [NREG];
  logic              loc_ack_q, loc_ack_d;
  logic [7:0]        loc_rd_q, loc_rd_d;
  logic              soft_rst_q, soft_rst_d;
  logic [EXT_AW-1:0] ext_addr_q, ext_addr_d;
  logic [7:0]        ext_wd_q, ext_wd_d;
  logic              ext_we_q, ext_we_d;
  logic              ext_re_q, ext_re_d;
  logic              ext_is_rd_q, ext_is_rd_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic [7:0]        to_cnt_q, to_cnt_d;

  logic [31:0]       loc_off_s;
  logic [31:0]       ext_off_s;
  logic              loc_hit_s;
  logic              ext_hit_s;
  logic [IW-1:0]     loc_idx_s;
  logic              wr_s;
  logic              rd_s;

  // Region decode; offsets are taken before the range check so base+size never overflows.
  assign loc_off_s = bus.loc_addr - BASE_ADDR;
  assign ext_off_s = bus.loc_addr - EXT_BASE;
  assign loc_hit_s = (bus.loc_addr >= BASE_ADDR) && (loc_off_s < 32'(NREG));
  assign ext_hit_s = (bus.loc_addr >= EXT_BASE) && ((ext_off_s >> EXT_AW) == 32'd0);
  assign loc_idx_s = loc_off_s[IW-1:0];
  assign wr_s      = bus.loc_act & bus.loc_we;
  assign rd_s      = bus.loc_act & bus.loc_re & ~bus.loc_we;

  // Next-state and registered-output logic for the access FSM.
  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    loc_ack_d   = 1'b0;
    loc_rd_d    = 8'h00;
    soft_rst_d  = 1'b0;
    ext_addr_d  = ext_addr_q;
    ext_wd_d    = ext_wd_q;
    ext_we_d    = 1'b0;
    ext_re_d    = 1'b0;
    ext_is_rd_d = ext_is_rd_q;
    tcnt_d      = tcnt_q;
    to_cnt_d    = to_cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_s || rd_s) begin
          if (loc_hit_s) begin
            if (wr_s) begin
              if (loc_idx_s == {IW{1'b0}}) begin
                soft_rst_d = 1'b1;
              end else begin
                regs_d[loc_idx_s] = bus.loc_wd;
              end
            end else begin
              loc_rd_d = (loc_idx_s == {IW{1'b0}}) ? VERSION : regs_q[loc_idx_s];
            end
            loc_ack_d = 1'b1;
            state_d   = ACK;
          end else if (ext_hit_s) begin
            ext_addr_d  = ext_off_s[EXT_AW-1:0];
            ext_wd_d    = bus.loc_wd;
            ext_we_d    = wr_s;
            ext_re_d    = rd_s;
            ext_is_rd_d = rd_s;
            tcnt_d      = 8'd0;
            state_d     = EXT_WAIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      EXT_WAIT: begin
        if (bus.ext_ack) begin
          loc_ack_d = 1'b1;
          loc_rd_d  = ext_is_rd_q ? bus.ext_rd : 8'h00;
          state_d   = ACK;
        end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
          // Abandon silently; the core turns the missing ACK into a bus error.
          tcnt_d   = 8'd0;
          to_cnt_d = (to_cnt_q == 8'hFF) ? 8'hFF : to_cnt_q + 8'd1;
          state_d  = IDLE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= 8'h00;
      end
      loc_ack_q   <= 1'b0;
      loc_rd_q    <= 8'h00;
      soft_rst_q  <= 1'b0;
      ext_addr_q  <= {EXT_AW{1'b0}};
      ext_wd_q    <= 8'h00;
      ext_we_q    <= 1'b0;
      ext_re_q    <= 1'b0;
      ext_is_rd_q <= 1'b0;
      tcnt_q      <= 8'd0;
      to_cnt_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      loc_ack_q   <= loc_ack_d;
      loc_rd_q    <= loc_rd_d;
      soft_rst_q  <= soft_rst_d;
      ext_addr_q  <= ext_addr_d;
      ext_wd_q    <= ext_wd_d;
      ext_we_q    <= ext_we_d;
      ext_re_q    <= ext_re_d;
      ext_is_rd_q <= ext_is_rd_d;
      tcnt_q      <= tcnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg_out
    assign reg_out_o[8*g +: 8] = regs_q[g];
  end

  assign bus.loc_ack  = loc_ack_q;
  assign bus.loc_rd   = loc_rd_q;
  assign bus.ext_addr = ext_addr_q;
  assign bus.ext_wd   = ext_wd_q;
  assign bus.ext_we   = ext_we_q;
  assign bus.ext_re   = ext_re_q;
  assign soft_rst_o   = soft_rst_q;
  assign to_cnt_o     = to_cnt_q;

endmodule

// File: tb/tb_rbcp_reg_bank.sv
// Directed bench for rbcp_reg_bank: local bank, external window, timeouts,
// decode misses, reset abandonment and combined write/read strobes.
module tb_rbcp_reg_bank;

  localparam int          NREG = 16;
  localparam int          TMO  = 20;
  localparam logic [31:0] EB   = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rbcp_reg_bank_if #(.EXT_AW(12)) bus ();
  logic [8*NREG-1:0] reg_out;
  logic              soft_rst;
  logic [7:0]        to_cnt;

  rbcp_reg_bank #(
    .BASE_ADDR(32'h0000_0000), .NREG(NREG), .VERSION(8'h01),
    .EXT_BASE(EB), .EXT_AW(12), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .reg_out_o(reg_out), .soft_rst_o(soft_rst), .to_cnt_o(to_cnt)
  );

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [127:0] exp_regs;
  logic         saw_ack;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; returns #1 after the edge that samples it.
  task automatic strobe(input logic act, input logic we, input logic re,
                        input logic [31:0] addr, input logic [7:0] wd);
    bus.loc_act  = act;
    bus.loc_we   = we;
    bus.loc_re   = re;
    bus.loc_addr = addr;
    bus.loc_wd   = wd;
    tick();
    bus.loc_we  = 1'b0;
    bus.loc_re  = 1'b0;
    bus.loc_act = 1'b0;
  endtask

  initial begin
    bus.loc_act = 1'b0; bus.loc_addr = 32'h0; bus.loc_wd = 8'h00;
    bus.loc_we = 1'b0; bus.loc_re = 1'b0; bus.ext_ack = 1'b0; bus.ext_rd = 8'h00;
    exp_regs = 128'h0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check_eq("rst_ack", bus.loc_ack, 1'b0);
    check_eq("rst_rd", bus.loc_rd, 8'h00);
    check_eq("rst_regs", reg_out, 128'h0);
    check_eq("rst_tocnt", to_cnt, 8'h00);
    check_eq("rst_extstb", {bus.ext_we, bus.ext_re, soft_rst}, 3'b000);

    // Local write then read-back of register 3
    strobe(1'b1, 1'b1, 1'b0, 32'h3, 8'hA5);
    exp_regs[31:24] = 8'hA5;
    check_eq("wr3_ack", bus.loc_ack, 1'b1);
    check_eq("wr3_regs", reg_out, exp_regs);
    check_eq("wr3_rd0", bus.loc_rd, 8'h00);
    tick();
    check_eq("wr3_ack_end", bus.loc_ack, 1'b0);
    strobe(1'b1, 1'b0, 1'b1, 32'h3, 8'h00);
    check_eq("rd3_ack", bus.loc_ack, 1'b1);
    check_eq("rd3_rd", bus.loc_rd, 8'hA5);
    tick();
    check_eq("rd3_idle", {bus.loc_ack, bus.loc_rd}, 9'h000);

    // Top register of the bank
    strobe(1'b1, 1'b1, 1'b0, 32'hF, 8'h77);
    exp_regs[127:120] = 8'h77;
    check_eq("wr15_regs", reg_out, exp_regs);
    tick();

    // Register 0: version readback, write gives soft reset only
    strobe(1'b1, 1'b0, 1'b1, 32'h0, 8'h00);
    check_eq("rd0_ver", bus.loc_rd, 8'h01);
    tick();
    strobe(1'b1, 1'b1, 1'b0, 32'h0, 8'h55);
    check_eq("wr0_ack_srst", {bus.loc_ack, soft_rst}, 2'b11);
    check_eq("wr0_regs", reg_out, exp_regs);
    tick();
    check_eq("wr0_srst_end", soft_rst, 1'b0);
    strobe(1'b1, 1'b0, 1'b1, 32'h0, 8'h00);
    check_eq("rd0_again", bus.loc_rd, 8'h01);
    tick();

    // External read, EXT_ACK five cycles after the strobe pulse
    strobe(1'b1, 1'b0, 1'b1, EB + 32'h7, 8'h00);
    check_eq("exr_re", {bus.ext_re, bus.ext_we}, 2'b10);
    check_eq("exr_addr", bus.ext_addr, 12'h007);
    check_eq("exr_noack", bus.loc_ack, 1'b0);
    tick();
    check_eq("exr_re_end", bus.ext_re, 1'b0);
    saw_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_ack = saw_ack | bus.loc_ack;
    end
    check_eq("exr_wait", saw_ack, 1'b0);
    bus.ext_ack = 1'b1; bus.ext_rd = 8'h3C;
    tick();
    bus.ext_ack = 1'b0;
    check_eq("exr_ack", {bus.loc_ack, bus.loc_rd}, {1'b1, 8'h3C});
    tick();
    check_eq("exr_end", {bus.loc_ack, bus.loc_rd}, 9'h000);

    // External write at top of window, EXT_ACK in the strobe-pulse cycle
    strobe(1'b1, 1'b1, 1'b0, EB + 32'hFFF, 8'h5A);
    check_eq("exw_stb", {bus.ext_we, bus.ext_addr, bus.ext_wd}, {1'b1, 12'hFFF, 8'h5A});
    bus.ext_ack = 1'b1; bus.ext_rd = 8'h99;
    tick();
    bus.ext_ack = 1'b0;
    check_eq("exw_ack", {bus.loc_ack, bus.loc_rd}, {1'b1, 8'h00});
    tick();

    // External write with no EXT_ACK: timeout after TMO cycles
    strobe(1'b1, 1'b1, 1'b0, EB + 32'h10, 8'h11);
    saw_ack = 1'b0;
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      saw_ack = saw_ack | bus.loc_ack;
    end
    check_eq("to_noack", saw_ack, 1'b0);
    check_eq("to_before", to_cnt, 8'd0);
    tick();
    check_eq("to_after", to_cnt, 8'd1);
    bus.ext_ack = 1'b1;
    tick();
    bus.ext_ack = 1'b0;
    check_eq("to_late_ack", bus.loc_ack, 1'b0);
    for (int n = 1; n < 300; n++) begin
      strobe(1'b1, 1'b1, 1'b0, EB, 8'h00);
      for (int i = 0; i < TMO; i++) tick();
    end
    check_eq("to_sat", to_cnt, 8'hFF);

    // Decode miss past the bank and a strobe without LOC_ACT
    strobe(1'b1, 1'b1, 1'b0, 32'h10, 8'hEE);
    check_eq("miss_ack", bus.loc_ack, 1'b0);
    tick();
    check_eq("miss_ack2", bus.loc_ack, 1'b0);
    strobe(1'b0, 1'b1, 1'b0, 32'h5, 8'hEE);
    check_eq("noact_ack", bus.loc_ack, 1'b0);
    tick();
    check_eq("noact_regs", reg_out, exp_regs);

    // Reset during EXT_WAIT abandons the access
    strobe(1'b1, 1'b0, 1'b1, EB + 32'h20, 8'h00);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.ext_ack = 1'b1; bus.ext_rd = 8'hC3;
    tick();
    bus.ext_ack = 1'b0;
    exp_regs = 128'h0;
    check_eq("rstw_ack", {bus.loc_ack, bus.loc_rd}, 9'h000);
    check_eq("rstw_regs", reg_out, exp_regs);
    check_eq("rstw_outs", {to_cnt, bus.ext_addr, bus.ext_re}, 21'h0);
    tick();
    check_eq("rstw_ack2", bus.loc_ack, 1'b0);

    // WE and RE together act as a single write
    strobe(1'b1, 1'b1, 1'b1, 32'h2, 8'h3C);
    exp_regs[23:16] = 8'h3C;
    check_eq("were_ack", {bus.loc_ack, bus.loc_rd}, {1'b1, 8'h00});
    check_eq("were_regs", reg_out, exp_regs);
    tick();
    check_eq("were_single", bus.loc_ack, 1'b0);
    tick();
    check_eq("were_single2", bus.loc_ack, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
